// File: rtl/spi_reg_slave.sv
// SPI register slave: receives 32-bit frames over SPI and writes 16-bit registers.
// Every new frame shifts out a status word with the last addressed register.
//
// Ports:
//   osc_clk      system clock; all logic runs on its rising edge
//   rst          synchronous active-high reset
//   SCK          SPI clock from the master (asynchronous)
//   SSEL         SPI select, active-low (asynchronous)
//   MOSI         serial data from the master (asynchronous)
//   MISO         serial readback data, MSB first
//   MISO_oe      pad enable, high while synchronized SSEL is low
//   frame_data   last good 32-bit word received
//   frame_valid  one-cycle pulse on a good 32-bit frame
//   frame_err    one-cycle pulse on a frame of any other length
//   Registers    8 x 16-bit register file, register n at [16n+15:16n]
module spi_reg_slave #(
    parameter int unsigned REG_COUNT  = 8,
    parameter logic [7:0]  STATUS_TAG = 8'hA5
) (
    input  logic         osc_clk,
    input  logic         rst,
    input  logic         SCK,
    input  logic         SSEL,
    input  logic         MOSI,
    output logic         MISO,
    output logic         MISO_oe,
    output logic [31:0]  frame_data,
    output logic         frame_valid,
    output logic         frame_err,
    output logic [127:0] Registers
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [4:0] REG_LIM = 5'(REG_COUNT);

    logic [2:0]  sck_s;
    logic [2:0]  ssel_s;
    logic [2:0]  mosi_s;
    logic        sync_live;
    logic        ssel_armed;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [31:0] rx_shift;
    logic [31:0] tx_shift;
    logic [3:0]  last_addr;

    logic        sck_rise;
    logic        sck_fall;
    logic        ssel_fall;
    logic        ssel_rise;
    logic        addr_ok;
    logic [15:0] rd_reg;

    // Two sync flops plus one history flop per pin.
    // ssel_armed only sets once a genuine high SSEL has been sampled after
    // reset, so SSEL already low at reset release cannot start a frame.
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            sck_s      <= 3'b000;
            ssel_s     <= 3'b111;
            mosi_s     <= 3'b000;
            sync_live  <= 1'b0;
            ssel_armed <= 1'b0;
        end else begin
            sck_s     <= {sck_s[1:0], SCK};
            ssel_s    <= {ssel_s[1:0], SSEL};
            mosi_s    <= {mosi_s[1:0], MOSI};
            sync_live <= 1'b1;
            if (sync_live && ssel_s[0])
                ssel_armed <= 1'b1;
        end
    end

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign ssel_fall = ~ssel_s[1] & ssel_s[2] & ssel_armed;
    assign ssel_rise = ssel_s[1] & ~ssel_s[2];

    assign addr_ok = {1'b0, rx_shift[19:16]} < REG_LIM;
    assign rd_reg  = ({1'b0, last_addr} < REG_LIM)
                   ? Registers[{last_addr[2:0], 4'h0} +: 16]
                   : 16'h0000;

    assign MISO    = tx_shift[31];
    assign MISO_oe = ~ssel_s[1];

    always_ff @(posedge osc_clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 6'd0;
            rx_shift    <= 32'h0;
            tx_shift    <= 32'h0;
            frame_data  <= 32'h0;
            last_addr   <= 4'h0;
            Registers   <= 128'h0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ssel_fall) begin
                        state    <= SHIFT;
                        bit_cnt  <= 6'd0;
                        tx_shift <= {STATUS_TAG, 4'h0, last_addr, rd_reg};
                    end
                end
                SHIFT: begin
                    // SSEL edges win over a coincident SCK edge.
                    if (ssel_rise) begin
                        state <= IDLE;
                        if (bit_cnt == 6'd32) begin
                            frame_data  <= rx_shift;
                            frame_valid <= 1'b1;
                            last_addr   <= rx_shift[19:16];
                            if (addr_ok)
                                Registers[{rx_shift[18:16], 4'h0} +: 16]
                                    <= rx_shift[15:0];
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[30:0], mosi_s[2]};
                        bit_cnt  <= (bit_cnt == 6'd33) ? 6'd33
                                                       : bit_cnt + 6'd1;
                    end else if (sck_fall) begin
                        tx_shift <= {tx_shift[30:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter: REG_COUNT, 8, number of 16-bit registers; fixed at 8 and used only for range checks.
REQ-002 SHALL have parameter: STATUS_TAG, 8'hA5, constant placed in bits [31:24] of the readback word.
REQ-003 SHALL have port: osc_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: SCK  input  1  SPI clock from master; asynchronous to osc_clk.
REQ-006 SHALL have port: SSEL  input  1  SPI select from master; active-low; asynchronous.
REQ-007 SHALL have port: MOSI  input  1  serial data from master; asynchronous.
REQ-008 SHALL have port: MISO  output  1  serial readback data to master.
REQ-009 SHALL have port: MISO_oe  output  1  high while the synchronized SSEL is low; drives the pad tristate.
REQ-010 SHALL have port: frame_data  output  32  last complete 32-bit word received.
REQ-011 SHALL have port: frame_valid  output  1  one-cycle pulse marking a good 32-bit frame.
REQ-012 SHALL have port: frame_err  output  1  one-cycle pulse marking a frame with a bit count other than 32.
REQ-013 SHALL have port: Registers  output  128  register file; register n occupies bits [16n+15:16n].

Function
REQ-014 SHALL pass SCK, SSEL and MOSI each through a 2-flop synchronizer, followed by a third history flop for edge detection.
REQ-015 SHALL detect each edge 3 osc_clk cycles after the pin transition.
REQ-016 SHALL require osc_clk >= 8x the SCK frequency; behaviour above that rate is undefined.
REQ-017 SHALL run a 2-state FSM: IDLE and SHIFT.
REQ-018 SHALL go from IDLE to SHIFT on a synchronized SSEL falling edge.
REQ-019 SHALL clear the bit counter when entering SHIFT.
REQ-020 SHALL, in SHIFT, shift the synchronized MOSI into rx_shift[0] on each synchronized SCK rising edge, MSB first.
REQ-021 SHALL increment a 6-bit bit counter on each such SCK rising edge, saturating at 33.
REQ-022 SHALL go from SHIFT to IDLE on a synchronized SSEL rising edge.
REQ-023 SHALL, on that SSEL rising edge with count == 32, load frame_data with rx_shift and pulse frame_valid high for exactly one cycle.
REQ-024 SHALL, on that SSEL rising edge with count != 32 (0..31 or saturated 33), pulse frame_err for one cycle and leave frame_data and Registers unchanged.
REQ-025 SHALL, on a good frame with frame_data[19:16] < 8, write frame_data[15:0] into register frame_data[19:16] in the same cycle frame_valid is asserted.
REQ-026 SHALL, when the address is >= 8, still pulse frame_valid but write no register.
REQ-027 SHALL ignore bits [31:20] of the received word.
REQ-028 SHALL latch last_addr = frame_data[19:16] on every good frame.
REQ-029 SHALL, on entry to SHIFT, load tx_shift = {STATUS_TAG, 4'h0, last_addr, Registers[last_addr]}, with the low 16 bits 0 when last_addr >= 8.
REQ-030 SHALL drive MISO = tx_shift[31] at all times.
REQ-031 SHALL shift tx_shift left by 1 on each synchronized SCK falling edge in SHIFT, filling with 0.
REQ-032 SHALL give SSEL edges priority over an SCK edge detected in the same cycle; that SCK edge is ignored.
REQ-033 SHALL ignore SCK and MOSI edges in IDLE.
REQ-034 SHALL ignore SSEL rising edges in IDLE.

Reset
REQ-035 SHALL, on rst, set FSM=IDLE, counter=0, rx_shift=0, tx_shift=0, frame_data=0, last_addr=0, and Registers=0.
REQ-036 SHALL hold frame_valid=0, frame_err=0, MISO=0 and MISO_oe=0 during reset.
REQ-037 SHALL initialize the synchronizer flops to SSEL=1, SCK=0, MOSI=0.
REQ-038 SHALL abort any frame in progress when rst is asserted mid-frame; no write and no error pulse.
REQ-039 SHALL, after such a reset, stay in IDLE until a new SSEL falling edge, even if SSEL is low when rst deasserts.

Verification
REQ-040 SHALL cover a good write: frame 32'h0003_BEEF at SCK = osc_clk/8 -> one frame_valid pulse, frame_data=32'h0003BEEF, Registers[63:48]=16'hBEEF, other bits 0.
REQ-041 SHALL cover readback: write 32'h0005_1234, then a second frame -> MISO bits in that frame read 32'hA505_1234.
REQ-042 SHALL cover a short frame: SSEL released after 31 SCK -> frame_err pulse, no frame_valid, Registers unchanged.
REQ-043 SHALL cover a long frame: 40 SCK then release -> frame_err pulse, no write.
REQ-044 SHALL cover an out-of-range address: 32'h000A_5555 -> frame_valid pulse, Registers unchanged, a following readback returns 32'hA50A_0000.
REQ-045 SHALL cover reset mid-frame: rst asserted after 16 bits with SSEL held low and then released, followed by a full frame 32'h0001_00FF -> no pulse for the aborted frame, one frame_valid for the new frame, Registers[31:16]=16'h00FF.
